// File: rtl/vga_fb_scanout.sv
// Scans a 320x240 RGB332 framebuffer out to 12-bit RGB with 2x pixel/line doubling.
// Each source row is prefetched into the back half of a ping-pong line buffer during blanking.
module vga_fb_scanout #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int V_TOTAL   = 525,
  parameter int SRC_W     = 320,
  parameter int WORDS     = 80,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [31:0] fb_base,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        underrun
);

  localparam int WW = $clog2(WORDS + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [WW-1:0] WORDS_C  = WW'(WORDS);
  localparam logic [OW-1:0] OUTST_C  = OW'(MAX_OUTST);
  localparam logic [9:0]    X_TRIG   = 10'(H_RES);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    Y_ACT_LS = 10'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] issued, received;
  logic [OW-1:0] outst;
  logic          front;
  logic [31:0]   base_q;
  logic [31:0]   row_addr;
  logic [31:0]   lbuf0 [WORDS];
  logic [31:0]   lbuf1 [WORDS];

  logic trig_pt, trig_frame, trig_row, trig, can_start, start;
  logic swap_pt, do_swap, issue, ret;

  assign trig_pt    = pix_ce && (x_in == X_TRIG);
  assign trig_frame = trig_pt && (y_in == Y_LAST);
  assign trig_row   = trig_pt && (y_in < Y_ACT_LS) && y_in[0];
  assign trig       = trig_frame || trig_row;
  assign can_start  = (state == IDLE) || (state == DONE);
  assign start      = trig && can_start;
  assign swap_pt    = pix_ce && (x_in == 10'd0) && active_in && !y_in[0];
  assign do_swap    = swap_pt && (state == DONE);

  assign mem_req = (state == REQ) && (issued < WORDS_C) && (outst < OUTST_C);
  assign issue   = mem_req && mem_gnt;
  assign ret     = mem_rvalid && ((state == REQ) || (state == DRAIN));

  // Frame fetch uses the live fb_base because it is being latched on this very edge.
  always_comb begin
    row_addr = fb_base;
    if (!trig_frame) row_addr = base_q + 32'((y_in + 10'd1) >> 1) * 32'(SRC_W);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = REQ;
      REQ:     if (issued == WORDS_C) state_nxt = DRAIN;
      DRAIN:   if (received == WORDS_C) state_nxt = DONE;
      DONE:    if (trig) state_nxt = REQ;
               else if (swap_pt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      issued   <= '0;
      received <= '0;
      outst    <= '0;
      front    <= 1'b0;
      base_q   <= '0;
      mem_addr <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        issued   <= '0;
        received <= '0;
        mem_addr <= row_addr;
        if (trig_frame) base_q <= fb_base;
      end else begin
        if (issue) begin
          issued   <= issued + WW'(1);
          mem_addr <= mem_addr + 32'd4;
        end
        if (ret) received <= received + WW'(1);
      end
      if (issue && !ret)      outst <= outst + OW'(1);
      else if (!issue && ret) outst <= outst - OW'(1);
      if (do_swap) front <= ~front;
      if ((trig && !can_start) || (swap_pt && state != DONE)) underrun <= 1'b1;
    end
  end

  // NOTE: line buffer storage is not reset; its contents are always rewritten before being shown.
  always_ff @(posedge clk) begin
    if (ret && received < WORDS_C) begin
      if (front) lbuf0[received] <= mem_rdata;
      else       lbuf1[received] <= mem_rdata;
    end
  end

  // Pixel path: the swap edge itself must already read the newly fetched buffer.
  logic [8:0]  sx;
  logic [6:0]  widx;
  logic        rd_sel;
  logic [31:0] rd_word;

  assign sx     = x_in[9:1];
  assign widx   = sx[8:2];
  assign rd_sel = front ^ do_swap;

  always_comb begin
    rd_word = '0;
    if (widx < 7'(WORDS)) rd_word = rd_sel ? lbuf1[widx] : lbuf0[widx];
  end

  logic [7:0] s1_pix;
  logic       s1_act, s1_hs, s1_vs;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_pix    <= '0;
      s1_act    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (pix_ce) begin
      s1_pix    <= rd_word[{sx[1:0], 3'b000} +: 8];
      s1_act    <= active_in;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      if (s1_act) begin
        r_out <= {s1_pix[7:5], s1_pix[7]};
        g_out <= {s1_pix[4:2], s1_pix[4]};
        b_out <= {s1_pix[1:0], s1_pix[1:0]};
      end else begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: drives timing fields directly and models an in-order memory.
module tb_vga_fb_scanout;

  logic        clk = 1'b0;
  logic        reset, pix_ce;
  logic [9:0]  x_in, y_in;
  logic        active_in, hsync_in, vsync_in;
  logic [31:0] fb_base;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic [3:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out, underrun;

  always #5 clk = ~clk;

  vga_fb_scanout dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .x_in(x_in), .y_in(y_in),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_base(fb_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .underrun(underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: row 0 has a few marked words, row 1 is all white, 0x2000 is green.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'hE01C03FF;
    if (a == 32'h1008) return 32'h00000092;
    if (a == 32'h113C) return 32'h000000E3;
    if (a >= 32'h1140 && a < 32'h1280) return 32'hFFFFFFFF;
    if (a == 32'h2000) return 32'h0000001C;
    return 32'h0;
  endfunction

  logic        gnt_en, rv_en;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  int          out_cnt = 0;
  int          max_out = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  assign mem_gnt = gnt_en;

  // In-order memory: data returns no earlier than the cycle after its grant.
  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && mem_req && mem_addr != prev_addr) stab_err++;
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      out_cnt = out_cnt + ((mem_req && mem_gnt) ? 1 : 0) - (mem_rvalid ? 1 : 0);
      if (out_cnt > max_out) max_out = out_cnt;
      mem_rvalid <= 1'b0;
      if (rv_en && pend.size() > 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_word(pend.pop_front());
      end
      if (mem_req && mem_gnt) begin
        pend.push_back(mem_addr);
        req_log.push_back(mem_addr);
      end
    end
  end

  // One pix_ce cycle, then one idle cycle with scrambled inputs that must be ignored.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic act,
                     input logic hs, input logic vs);
    x_in = x; y_in = y; active_in = act; hsync_in = hs; vsync_in = vs; pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0; x_in = 10'd0; y_in = 10'd0; active_in = 1'b1;
    hsync_in = ~hs; vsync_in = ~vs;
    @(negedge clk);
  endtask

  task automatic chk_px(input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp,
                        input string tag);
    pix(x, y, 1'b1, 1'b0, 1'b0);
    pix(x + 10'd1, y, 1'b1, 1'b0, 1'b0);
    check(tag, {20'h0, r_out, g_out, b_out}, {20'h0, exp});
  endtask

  int          px_x   [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 16, 632, 633};
  logic [11:0] px_row0[12] = '{12'hFFF, 12'hFFF, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0,
                               12'hF00, 12'hF00, 12'h000, 12'h99A, 12'hF0F, 12'hF0F};

  task automatic show_row0(input logic [9:0] y);
    for (int i = 0; i < 12; i++)
      chk_px(10'(px_x[i]), y, px_row0[i], $sformatf("line%0d_x%0d", y, px_x[i]));
  endtask

  task automatic wait_fetch(input int n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (req_log.size() == n && pend.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, {31'h0, ok}, 32'h1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int         base_n;
  int         bad;
  logic [31:0] a0;
  logic [7:0] hs_pat = 8'b0001_1100;
  logic [7:0] vs_pat = 8'b0011_0000;

  initial begin
    reset = 1'b1; pix_ce = 1'b0; x_in = '0; y_in = '0; active_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; fb_base = 32'h1000; gnt_en = 1'b1; rv_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_rgb", {20'h0, r_out, g_out, b_out}, 32'h0);
    check("rst_sync", {30'h0, hsync_out, vsync_out}, 32'h0);
    check("rst_underrun", {31'h0, underrun}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Row 0 fetch at end of frame
    pix(10'd640, 10'd524, 1'b0, 1'b0, 1'b0);
    wait_fetch(80, "fetch0_done");
    check("fetch0_count", req_log.size(), 80);
    check("fetch0_first", req_log[0], 32'h1000);
    check("fetch0_last", req_log[79], 32'h113C);
    bad = 0;
    for (int i = 1; i < 80; i++) if (req_log[i] != req_log[i-1] + 32'd4) bad++;
    check("fetch0_stride", bad, 0);
    check("fetch0_underrun", {31'h0, underrun}, 32'h0);

    // Lines 0 and 1 both show row 0
    show_row0(10'd0);
    show_row0(10'd1);
    check("line01_underrun", {31'h0, underrun}, 32'h0);

    // Sync delay of two pix_ce stages, RGB blank
    for (int i = 0; i < 8; i++) begin
      pix(10'(650 + i), 10'd1, 1'b0, hs_pat[i], vs_pat[i]);
      if (i >= 1) begin
        check($sformatf("hsync_%0d", i), {31'h0, hsync_out}, {31'h0, hs_pat[i-1]});
        check($sformatf("vsync_%0d", i), {31'h0, vsync_out}, {31'h0, vs_pat[i-1]});
        check($sformatf("blank_rgb_%0d", i), {20'h0, r_out, g_out, b_out}, 32'h0);
      end
    end

    // Row 1 fetch: grant stall, then return stall causing underrun at line 2
    pix(10'd640, 10'd1, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    gnt_en = 1'b0;
    a0 = mem_addr;
    check("stall_addr_start", a0, 32'h1140 + 32'(4 * (req_log.size() - 80)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_req_%0d", i), {31'h0, mem_req}, 32'h1);
      check($sformatf("stall_addr_%0d", i), mem_addr, a0);
    end
    rv_en = 1'b0;
    gnt_en = 1'b1;
    repeat (10) @(negedge clk);
    check("outst_cap_req", {31'h0, mem_req}, 32'h0);
    check("outst_cap_cnt", out_cnt, 4);

    show_row0(10'd2);
    check("underrun_set", {31'h0, underrun}, 32'h1);
    show_row0(10'd3);

    rv_en = 1'b1;
    wait_fetch(160, "fetch1_done");
    check("fetch1_first", req_log[80], 32'h1140);
    check("fetch1_last", req_log[159], 32'h127C);
    chk_px(10'd0, 10'd4, 12'hFFF, "line4_x0");
    chk_px(10'd8, 10'd4, 12'hFFF, "line4_x8");
    chk_px(10'd632, 10'd4, 12'hFFF, "line4_x632");
    check("underrun_sticky", {31'h0, underrun}, 32'h1);

    // Reset while the fetch is requesting
    fb_base = 32'h2000;
    pix(10'd640, 10'd524, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("req_before_reset", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req", {31'h0, mem_req}, 32'h0);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_rgb", {20'h0, r_out, g_out, b_out}, 32'h0);
    check("midrst_sync", {30'h0, hsync_out, vsync_out}, 32'h0);
    check("midrst_underrun", {31'h0, underrun}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    base_n = req_log.size();
    pix(10'd640, 10'd524, 1'b0, 1'b0, 1'b0);
    wait_fetch(base_n + 80, "fetch2_done");
    check("fetch2_first", req_log[base_n], 32'h2000);
    check("fetch2_last", req_log[base_n + 79], 32'h213C);
    chk_px(10'd0, 10'd0, 12'h0F0, "post_rst_x0");
    check("post_rst_underrun", {31'h0, underrun}, 32'h0);

    check("addr_stable", stab_err, 0);
    check("max_outst", max_out, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Downstream consumer of the VGA timing generator.
- Converts the timing stream (x, y, active, syncs) into 12-bit RGB by scanning out a 320x240 RGB332 framebuffer from system memory with 2x pixel/line doubling.
- Prefetches each source row into a ping-pong line buffer during horizontal blanking.
- Delays the syncs to stay aligned with the pixel data.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- V_TOTAL, 525, total lines per frame including blanking
- SRC_W, 320, source pixels per row (H_RES/2)
- WORDS, 80, 32-bit words per source row (SRC_W/4)
- MAX_OUTST, 4, maximum outstanding memory reads

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_ce  in  1  pixel-rate enable from the timing generator; the pipeline advances only when high
- x_in  in  10  current pixel column
- y_in  in  10  current line
- active_in  in  1  visible-region flag
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- fb_base  in  32  framebuffer byte base address; word-aligned
- mem_req  out  1  read request
- mem_addr  out  32  read byte address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; returned in request order
- mem_rdata  in  32  read data
- r_out  out  4  red
- g_out  out  4  green
- b_out  out  4  blue
- hsync_out  out  1  hsync delayed to match RGB
- vsync_out  out  1  vsync delayed to match RGB
- underrun  out  1  sticky: a line began displaying before its fetch completed

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; outstanding and word counters 0; front buffer index 0.
  - Line buffer contents undefined.
- Fetch trigger: evaluated only on a pix_ce cycle with x_in == H_RES.
  - y_in == V_TOTAL-1: fetch source row 0 and latch fb_base for the frame.
  - y_in < V_RES-1 and y_in[0] == 1: fetch source row (y_in+1)>>1.
  - Otherwise: no fetch.
- Fetch target is always the back buffer. Word k of row r is read from latched_base + r*SRC_W + 4*k.
- FSM:
  - IDLE -> REQ on trigger; word and response counters cleared.
  - REQ: mem_req=1 while issued < WORDS and outstanding < MAX_OUTST.
    - Each mem_gnt increments the issued count and advances mem_addr by 4.
    - mem_addr must remain stable while mem_req=1 and mem_gnt=0.
  - REQ -> DRAIN when issued == WORDS.
  - DRAIN -> DONE when received == WORDS. Each mem_rvalid writes mem_rdata to back[received] and increments received.
  - mem_gnt and mem_rvalid in the same cycle: outstanding count unchanged.
  - DONE -> IDLE at the swap point.
- Swap: on a pix_ce cycle with x_in == 0, active_in == 1 and y_in[0] == 0, front/back are exchanged if the FSM is in DONE.
  - If the FSM is not in DONE: no swap, underrun <= 1, the current front buffer is redisplayed, and the fetch continues.
- Trigger arriving while the FSM is not IDLE or DONE: the trigger is ignored and underrun <= 1.
- Pixel path, 2 pix_ce stages:
  - Stage 1: sx = x_in>>1; read front[sx>>2]; capture byte sx[1:0] (byte 0 = bits 7:0 = leftmost pixel).
  - Stage 2 expansion: r_out = {R[2:0], R[2]}, g_out = {G[2:0], G[2]}, b_out = {B[1:0], B[1:0]}.
  - RGB332 bit layout: R = bits 7:5, G = bits 4:2, B = bits 1:0.
  - When delayed active == 0, RGB is forced to 0.
- hsync, vsync and active are each delayed exactly 2 pix_ce stages. No output changes on cycles where pix_ce == 0.
- underrun clears only on reset.
- Reset mid-fetch: the FSM returns to IDLE immediately. The memory fabric shares this reset, so no stale rvalid arrives after it.

Test Plan:
- Frame with fb_base=0x1000, zero-latency memory that grants every cycle -> the row-0 fetch at y=524, x=640 issues addresses 0x1000..0x113C (80 requests, stride 4); underrun stays 0.
- Word 0 of row 0 = 0xE01C03FF -> line 0 shows 2 px 0xFFF, 2 px 0x00F, 2 px 0x0F0, 2 px 0xF00. Lines 0 and 1 are identical.
- hsync_in pulse -> hsync_out pulses 2 pix_ce cycles later with identical width. RGB = 0 during blanking.
- mem_gnt held low 5 cycles mid-fetch -> mem_req and mem_addr stay stable. Outstanding never exceeds 4.
- Memory stalled so that row 1 is not done at y=2, x=0 -> underrun rises and stays 1; lines 2-3 repeat row 0.
- reset asserted during REQ -> the next cycle has mem_req=0 and all outputs 0; the next frame fetches normally.
